// File: rtl/rv32_bus_pkg.sv
// Shared types for the rv32 bus arbiter: FSM states, arbitration modes and a ring-index helper.
package rv32_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_RESPONSE = 2'd2
    } arb_state_e;

    localparam int MODE_FIXED       = 0;
    localparam int MODE_ROUND_ROBIN = 1;

    // (base + off) mod n for base < n and off <= n, without a divider.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/rv32_bus_arbiter_if.sv
// Request/response and downstream bus bundle; slave = arbiter view, master = environment view.
interface rv32_bus_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]              req_valid_in;
    logic [NUM_PORTS-1:0]              req_ready_out;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_address_in;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_write_mask_in;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   req_write_value_in;
    logic [NUM_PORTS-1:0]              resp_valid_out;
    logic [DATA_WIDTH-1:0]             resp_read_value_out;
    logic                              bus_valid_out;
    logic                              bus_ready_in;
    logic [ADDR_WIDTH-1:0]             bus_address_out;
    logic [DATA_WIDTH/8-1:0]           bus_write_mask_out;
    logic [DATA_WIDTH-1:0]             bus_write_value_out;
    logic                              bus_resp_valid_in;
    logic [DATA_WIDTH-1:0]             bus_read_value_in;

    modport slave (
        input  req_valid_in, req_address_in, req_write_mask_in, req_write_value_in,
        input  bus_ready_in, bus_resp_valid_in, bus_read_value_in,
        output req_ready_out, resp_valid_out, resp_read_value_out,
        output bus_valid_out, bus_address_out, bus_write_mask_out, bus_write_value_out
    );

    modport master (
        output req_valid_in, req_address_in, req_write_mask_in, req_write_value_in,
        output bus_ready_in, bus_resp_valid_in, bus_read_value_in,
        input  req_ready_out, resp_valid_out, resp_read_value_out,
        input  bus_valid_out, bus_address_out, bus_write_mask_out, bus_write_value_out
    );
endinterface

// File: rtl/rv32_bus_arbiter_select.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin from ptr.
// Zero latency; pure function of requests and pointer, no backpressure of its own.
module rv32_bus_arbiter_select
    import rv32_bus_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ROUND_ROBIN = MODE_FIXED,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    always_comb begin
        logic [IDX_W-1:0] p;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        p     = '0;
        // Walk the ring starting at the search origin; first hit wins.
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (ROUND_ROBIN == MODE_ROUND_ROBIN) begin
                p = IDX_W'(wrap_add(32'(ptr), k, NUM_PORTS));
            end else begin
                p = IDX_W'(k);
            end
            if (!any && req[p]) begin
                any      = 1'b1;
                grant[p] = 1'b1;
                idx      = p;
            end
        end
    end

endmodule

// File: rtl/rv32_bus_arbiter.sv
// N-port to single-bus arbiter, one transaction outstanding; grant in IDLE, hold fields in REQUEST.
// Latency: 1 cycle grant->bus_valid, response pulse the cycle after completion; 2 cycles min per txn.
// Backpressure: bus_ready_in stalls REQUEST with fields stable; response wait in RESPONSE is unbounded.
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = MODE_FIXED
) (
    input  logic                clk,
    input  logic                reset_n,
    rv32_bus_arbiter_if.slave   arb_if
);

    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int MASK_W = DATA_WIDTH / 8;

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [MASK_W-1:0]       mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_PORTS-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [NUM_PORTS-1:0]    req_ready;
    logic                    bus_valid;
    logic                    complete;

    logic [NUM_PORTS-1:0]    sel_grant;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_any;

    logic [ADDR_WIDTH-1:0]   port_addr  [NUM_PORTS];
    logic [MASK_W-1:0]       port_mask  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]   port_wdata [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign port_addr[g]  = arb_if.req_address_in[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_mask[g]  = arb_if.req_write_mask_in[g*MASK_W +: MASK_W];
        assign port_wdata[g] = arb_if.req_write_value_in[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rv32_bus_arbiter_select #(
        .NUM_PORTS   (NUM_PORTS),
        .ROUND_ROBIN (ROUND_ROBIN),
        .IDX_W       (IDX_W)
    ) u_select (
        .req   (arb_if.req_valid_in),
        .ptr   (ptr_q),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        resp_valid_d = '0;
        rdata_d      = rdata_q;
        req_ready    = '0;
        bus_valid    = 1'b0;
        complete     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Late or spurious bus responses are deliberately not looked at here.
                if (sel_any) begin
                    req_ready = sel_grant;
                    idx_d     = sel_idx;
                    addr_d    = port_addr[sel_idx];
                    mask_d    = port_mask[sel_idx];
                    wdata_d   = port_wdata[sel_idx];
                    if (ROUND_ROBIN == MODE_ROUND_ROBIN) begin
                        ptr_d = IDX_W'(wrap_add(32'(sel_idx), 1, NUM_PORTS));
                    end
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                bus_valid = 1'b1;
                if (arb_if.bus_ready_in) begin
                    if (arb_if.bus_resp_valid_in) complete = 1'b1;
                    else                          state_d  = ST_RESPONSE;
                end
            end
            ST_RESPONSE: begin
                if (arb_if.bus_resp_valid_in) complete = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            state_d             = ST_IDLE;
            resp_valid_d[idx_q] = 1'b1;
            rdata_d             = arb_if.bus_read_value_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    // The grant is combinational from IDLE, so it must be masked while reset is held.
    assign arb_if.req_ready_out       = req_ready & {NUM_PORTS{reset_n}};
    assign arb_if.bus_valid_out       = bus_valid;
    assign arb_if.bus_address_out     = addr_q;
    assign arb_if.bus_write_mask_out  = mask_q;
    assign arb_if.bus_write_value_out = wdata_q;
    assign arb_if.resp_valid_out      = resp_valid_q;
    assign arb_if.resp_read_value_out = rdata_q;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with identical stimulus against a transaction-level model.
module tb_rv32_bus_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    req_valid = '0;
    logic [NP*AW-1:0] addr_flat = '0;
    logic [NP*MW-1:0] mask_flat = '0;
    logic [NP*DW-1:0] wdata_flat = '0;
    logic             bus_ready = 1'b0;
    logic             bus_resp = 1'b0;
    logic [DW-1:0]    bus_rdata = '0;

    rv32_bus_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_f ();
    rv32_bus_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_r ();

    assign if_f.req_valid_in       = req_valid;
    assign if_f.req_address_in     = addr_flat;
    assign if_f.req_write_mask_in  = mask_flat;
    assign if_f.req_write_value_in = wdata_flat;
    assign if_f.bus_ready_in       = bus_ready;
    assign if_f.bus_resp_valid_in  = bus_resp;
    assign if_f.bus_read_value_in  = bus_rdata;
    assign if_r.req_valid_in       = req_valid;
    assign if_r.req_address_in     = addr_flat;
    assign if_r.req_write_mask_in  = mask_flat;
    assign if_r.req_write_value_in = wdata_flat;
    assign if_r.bus_ready_in       = bus_ready;
    assign if_r.bus_resp_valid_in  = bus_resp;
    assign if_r.bus_read_value_in  = bus_rdata;

    rv32_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) dut_fixed (
        .clk(clk), .reset_n(reset_n), .arb_if(if_f));
    rv32_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .reset_n(reset_n), .arb_if(if_r));

    // Observed outputs, index 0 = fixed priority, 1 = round-robin.
    logic [NP-1:0] o_ready [2];
    logic          o_bvld  [2];
    logic [AW-1:0] o_baddr [2];
    logic [MW-1:0] o_bmask [2];
    logic [DW-1:0] o_bdata [2];
    logic [NP-1:0] o_resp  [2];
    logic [DW-1:0] o_rdata [2];
    assign o_ready[0] = if_f.req_ready_out;   assign o_ready[1] = if_r.req_ready_out;
    assign o_bvld[0]  = if_f.bus_valid_out;   assign o_bvld[1]  = if_r.bus_valid_out;
    assign o_baddr[0] = if_f.bus_address_out; assign o_baddr[1] = if_r.bus_address_out;
    assign o_bmask[0] = if_f.bus_write_mask_out;  assign o_bmask[1] = if_r.bus_write_mask_out;
    assign o_bdata[0] = if_f.bus_write_value_out; assign o_bdata[1] = if_r.bus_write_value_out;
    assign o_resp[0]  = if_f.resp_valid_out;  assign o_resp[1]  = if_r.resp_valid_out;
    assign o_rdata[0] = if_f.resp_read_value_out; assign o_rdata[1] = if_r.resp_read_value_out;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level reference: is a transaction open, has the bus taken it, who owns it.
    bit            m_busy;
    bit            m_taken;
    int            m_owner [2];
    int            m_ptr   [2];
    logic [AW-1:0] m_addr  [2];
    logic [MW-1:0] m_mask  [2];
    logic [DW-1:0] m_wdata [2];
    logic [NP-1:0] m_resp  [2];
    logic [DW-1:0] m_rdata;

    function automatic string nm(input int d, input string s);
        return (d == 0) ? {"fix.", s} : {"rr.", s};
    endfunction

    function automatic int winner(input int d, input logic [NP-1:0] req);
        int start;
        start = (d == 0) ? 0 : m_ptr[d];
        for (int k = 0; k < NP; k++) begin
            if (req[(start + k) % NP]) return (start + k) % NP;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_taken = 0;
        m_rdata = '0;
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = 0; m_ptr[d] = 0;
            m_addr[d] = '0; m_mask[d] = '0; m_wdata[d] = '0; m_resp[d] = '0;
        end
    endtask

    task automatic model_edge();
        bit done;
        int w;
        done = 0;
        if (!m_busy) begin
            if (req_valid != '0) begin
                for (int d = 0; d < 2; d++) begin
                    w = winner(d, req_valid);
                    m_owner[d] = w;
                    m_addr[d]  = addr_flat[w*AW +: AW];
                    m_mask[d]  = mask_flat[w*MW +: MW];
                    m_wdata[d] = wdata_flat[w*DW +: DW];
                    if (d == 1) m_ptr[d] = (w + 1) % NP;
                end
                m_busy  = 1;
                m_taken = 0;
            end
        end else if (!m_taken) begin
            if (bus_ready) begin
                if (bus_resp) done = 1;
                else          m_taken = 1;
            end
        end else if (bus_resp) begin
            done = 1;
        end
        for (int d = 0; d < 2; d++) m_resp[d] = done ? NP'(1 << m_owner[d]) : '0;
        if (done) begin
            m_busy  = 0;
            m_taken = 0;
            m_rdata = bus_rdata;
        end
    endtask

    task automatic compare_all();
        int w;
        logic [NP-1:0] exp_rdy;
        for (int d = 0; d < 2; d++) begin
            w = winner(d, req_valid);
            exp_rdy = (!m_busy && w >= 0) ? NP'(1 << w) : '0;
            check_val(nm(d, "req_ready"), 64'(o_ready[d]), 64'(exp_rdy));
            check_val(nm(d, "bus_valid"), 64'(o_bvld[d]), 64'(m_busy && !m_taken));
            check_val(nm(d, "bus_addr"), 64'(o_baddr[d]), 64'(m_addr[d]));
            check_val(nm(d, "bus_mask"), 64'(o_bmask[d]), 64'(m_mask[d]));
            check_val(nm(d, "bus_wdata"), 64'(o_bdata[d]), 64'(m_wdata[d]));
            check_val(nm(d, "resp_valid"), 64'(o_resp[d]), 64'(m_resp[d]));
            check_val(nm(d, "resp_rdata"), 64'(o_rdata[d]), 64'(m_rdata));
        end
    endtask

    task automatic check_all_zero(input string pfx);
        for (int d = 0; d < 2; d++) begin
            check_val(nm(d, {pfx, ".req_ready"}), 64'(o_ready[d]), 64'd0);
            check_val(nm(d, {pfx, ".bus_valid"}), 64'(o_bvld[d]), 64'd0);
            check_val(nm(d, {pfx, ".bus_addr"}), 64'(o_baddr[d]), 64'd0);
            check_val(nm(d, {pfx, ".bus_mask"}), 64'(o_bmask[d]), 64'd0);
            check_val(nm(d, {pfx, ".bus_wdata"}), 64'(o_bdata[d]), 64'd0);
            check_val(nm(d, {pfx, ".resp_valid"}), 64'(o_resp[d]), 64'd0);
            check_val(nm(d, {pfx, ".resp_rdata"}), 64'(o_rdata[d]), 64'd0);
        end
    endtask

    // One clock: sample outputs mid-cycle, advance the model on the edge, then let the caller drive.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [MW-1:0] m,
                            input logic [DW-1:0] v);
        addr_flat[p*AW +: AW]  = a;
        mask_flat[p*MW +: MW]  = m;
        wdata_flat[p*DW +: DW] = v;
    endtask

    task automatic drain();
        req_valid = '0; bus_ready = 1'b1; bus_resp = 1'b1;
        repeat (3) cycle();
        bus_resp = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        req_valid = 3'b111;
        #1 check_all_zero("por");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        req_valid = '0;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = NP'($urandom_range(0, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) set_port(p, $urandom, MW'($urandom), $urandom);
            bus_ready = ($urandom_range(0, 99) < 60);
            bus_resp  = ($urandom_range(0, 99) < 45);
            bus_rdata = $urandom;
            cycle();
        end

        // Ports 0 and 1 requesting continuously with an immediate bus.
        drain();
        req_valid = 3'b011; bus_ready = 1'b1; bus_resp = 1'b1;
        for (int i = 0; i < 8; i++) begin bus_rdata = $urandom; cycle(); end

        // Round-robin over all three ports.
        drain();
        req_valid = 3'b111; bus_ready = 1'b1; bus_resp = 1'b1;
        for (int i = 0; i < 8; i++) begin bus_rdata = $urandom; cycle(); end

        // Port 1 write held off by bus_ready for three cycles.
        drain();
        set_port(1, 32'h100, 4'b0011, 32'hDEADBEEF);
        req_valid = 3'b010; bus_ready = 1'b0; bus_resp = 1'b0;
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        bus_ready = 1'b1; bus_resp = 1'b1; bus_rdata = 32'hCAFE0001;
        cycle();
        bus_ready = 1'b0; bus_resp = 1'b0;
        repeat (2) cycle();

        // Port 0 read with the response five cycles after the handshake.
        set_port(0, 32'h40, 4'b0000, 32'h0);
        req_valid = 3'b001;
        cycle();
        req_valid = '0; bus_ready = 1'b1;
        cycle();
        bus_ready = 1'b0;
        repeat (5) cycle();
        bus_resp = 1'b1; bus_rdata = 32'h12345678;
        cycle();
        bus_resp = 1'b0;
        repeat (2) cycle();

        // Reset while waiting for a response; round-robin pointer is 1 beforehand.
        drain();
        req_valid = 3'b001; bus_ready = 1'b1; bus_resp = 1'b0;
        cycle();
        req_valid = '0;
        cycle();
        bus_ready = 1'b0;
        cycle();
        req_valid = 3'b101;
        reset_n = 1'b0;
        #1 check_all_zero("arst");
        model_reset();
        bus_resp = 1'b1; bus_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1 check_all_zero("arst_hold");
        reset_n = 1'b1;
        bus_resp = 1'b0;
        req_valid = 3'b101; bus_ready = 1'b1;
        cycle();
        req_valid = '0; bus_resp = 1'b1; bus_rdata = 32'h0000_A5A5;
        cycle();
        bus_resp = 1'b0;
        cycle();

        // Spurious bus responses while idle.
        req_valid = '0; bus_resp = 1'b1; bus_rdata = 32'hFFFF_0000;
        repeat (3) cycle();
        bus_resp = 1'b0;
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
